branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath/PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, power-of-two BHT depth.
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  branch resolve request.
REQ-006 SHALL have port req_ready  output  1  request accepted when valid&ready.
REQ-007 SHALL have port req_pc  input  WIDTH  PC of the branch.
REQ-008 SHALL have ports req_src_a, req_src_b  input  WIDTH  compare operands.
REQ-009 SHALL have port req_op  input  branch_op_e  compare type (EQ/NE/LT/GE/LTU/GEU).
REQ-010 SHALL have port req_imm  input  WIDTH  sign-extended branch offset.
REQ-011 SHALL have port req_pred_taken  input  1  prediction fetch used.
REQ-012 SHALL have ports lookup_pc  input  WIDTH, lookup_taken  output  1  combinational BHT prediction.
REQ-013 SHALL have ports redirect_valid  output  1, redirect_ready  input  1, redirect_pc  output  WIDTH  corrected fetch target.
REQ-014 SHALL have port flush  output  1  one-cycle pipeline flush pulse.
REQ-015 SHALL have port resolve_done  output  1  one-cycle pulse per resolved branch.
REQ-016 SHALL have ports branch_count, mispredict_count  output  16  statistics.

Function
REQ-017 SHALL implement FSM states IDLE, EVAL, REDIRECT; req_ready=1 only in IDLE.
REQ-018 SHALL, on IDLE with req_valid, register pc/src_a/src_b/op/imm/pred_taken and enter EVAL next cycle.
REQ-019 SHALL in EVAL drive the internal branch unit with registered operands, is_branch=1 (0 in all other states).
REQ-020 SHALL in EVAL compute target = pc+imm (taken) or pc+4 (not taken), modulo 2^WIDTH.
REQ-021 SHALL in EVAL flag mispredict = taken XOR pred_taken; pulse resolve_done; increment branch_count; increment mispredict_count on mispredict.
REQ-022 SHALL saturate both counters at 16'hFFFF (no wrap).
REQ-023 SHALL go EVAL->IDLE if no mispredict, EVAL->REDIRECT if mispredict.
REQ-024 SHALL assert flush exactly in the first REDIRECT cycle.
REQ-025 SHALL hold redirect_valid=1 and redirect_pc stable throughout REDIRECT; REDIRECT->IDLE on cycle redirect_ready=1.
REQ-026 SHALL index BHT with pc[log2(BHT_ENTRIES)+1:2]; entries are 2-bit saturating counters; lookup_taken = counter MSB.
REQ-027 SHALL update BHT in EVAL: +1 if taken (sat 3), -1 if not (sat 0).
REQ-028 SHALL return the pre-update counter on lookup to the index being updated in the same cycle.
REQ-029 SHALL ignore req_valid outside IDLE (no buffering).

Reset
REQ-030 SHALL on rst_n=0 immediately force IDLE, req_ready=1, redirect_valid=0, flush=0, resolve_done=0, redirect_pc=0, counters=0, all BHT entries=2'b01.
REQ-031 SHALL abort any in-flight EVAL/REDIRECT on reset with no BHT/counter update.

Structure
REQ-032 SHALL take branch_op_e from branches_pkg; the FSM state enum and BHT counter reset constant SHALL be added to branches_pkg.
REQ-033 SHALL instantiate existing branch_unit (WIDTH) as the sole sub-module for compare evaluation.

Verification
REQ-034 SHALL cover: BEQ a=b=0xA, pc=0x100, imm=0x20, pred=1 -> no redirect, resolve_done 1 pulse, branch_count=1, BHT[0] 01->10.
REQ-035 SHALL cover: BLTU a=0, b=0xFFFFFFFF, pc=0x40, imm=-8, pred=0 -> flush 1 cycle, redirect_pc=0x38, mispredict_count=1.
REQ-036 SHALL cover: BGE a=1, b=2, pred=1, redirect_ready low 3 cycles -> redirect_valid/pc held 3 cycles, req_ready=0, IDLE after ready, redirect_pc=pc+4.
REQ-037 SHALL cover: 3 taken branches at same pc -> counter saturates at 3, lookup_taken=1; same-cycle lookup returns old value.
REQ-038 SHALL cover: rst_n low during REDIRECT -> redirect_valid drops without clock edge, counters 0, lookup_taken=0 all indices.
REQ-039 SHALL cover: counters preloaded/driven to 0xFFFF -> further branches keep 0xFFFF.

Source files
------------

// File: rtl/branches_pkg.sv
// rtl/branches_pkg.sv - shared types and constants for branch resolution
// Contents: branch_op_e compare encoding, branch_ctrl FSM states, BHT counter
// reset value, statistics counter limit, saturating update helpers.
package branches_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } branch_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2
  } bc_state_e;

  // Weakly not-taken: one taken branch flips the prediction.
  localparam logic [1:0]  BHT_RESET = 2'b01;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

  function automatic logic [1:0] bht_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch compare and target computation
// Ports: is_branch (qualifies taken), op, pc, src_a, src_b, imm in;
//        taken, target (pc+imm if taken else pc+4, modulo 2^WIDTH) out.
module branch_unit
  import branches_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_branch,
  input  branch_op_e       op,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] imm,
  output logic             taken,
  output logic [WIDTH-1:0] target
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (op)
      BR_EQ:   cond = (src_a == src_b);
      BR_NE:   cond = (src_a != src_b);
      BR_LT:   cond = ($signed(src_a) <  $signed(src_b));
      BR_GE:   cond = ($signed(src_a) >= $signed(src_b));
      BR_LTU:  cond = (src_a <  src_b);
      BR_GEU:  cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
    taken  = is_branch & cond;
    target = taken ? (pc + imm) : (pc + WIDTH'(4));
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolve controller with bimodal BHT
// Ports: clk, rst_n (async active-low); req_* resolve request (valid/ready);
//        lookup_pc/lookup_taken combinational BHT prediction;
//        redirect_valid/ready/pc corrected fetch target; flush, resolve_done
//        pulses; branch_count/mispredict_count saturating statistics.
// CNT_RESET is the statistics counters' reset value (0 in normal use).
module branch_ctrl
  import branches_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          BHT_ENTRIES = 16,
  parameter logic [15:0] CNT_RESET   = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_pc,
  input  logic [WIDTH-1:0] req_src_a,
  input  logic [WIDTH-1:0] req_src_b,
  input  branch_op_e       req_op,
  input  logic [WIDTH-1:0] req_imm,
  input  logic             req_pred_taken,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             lookup_taken,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush,
  output logic             resolve_done,
  output logic [15:0]      branch_count,
  output logic [15:0]      mispredict_count
);

  localparam int IDXW = $clog2(BHT_ENTRIES);

  bc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] src_a_q, src_a_d;
  logic [WIDTH-1:0] src_b_q, src_b_d;
  branch_op_e       op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             pred_q, pred_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  logic [15:0]      branch_count_q, branch_count_d;
  logic [15:0]      mispredict_count_q, mispredict_count_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];

  logic             is_branch;
  logic             bu_taken;
  logic [WIDTH-1:0] bu_target;
  logic             mispredict;
  logic [IDXW-1:0]  upd_idx;
  logic [IDXW-1:0]  lookup_idx;
  logic             unused_lookup_bits;

  branch_unit #(.WIDTH(WIDTH)) u_branch_unit (
    .is_branch (is_branch),
    .op        (op_q),
    .pc        (pc_q),
    .src_a     (src_a_q),
    .src_b     (src_b_q),
    .imm       (imm_q),
    .taken     (bu_taken),
    .target    (bu_target)
  );

  assign upd_idx    = pc_q[IDXW+1:2];
  assign lookup_idx = lookup_pc[IDXW+1:2];
  assign unused_lookup_bits = ^{lookup_pc[WIDTH-1:IDXW+2], lookup_pc[1:0]};

  // Reads registered state only, so a lookup colliding with the EVAL update
  // sees the pre-update counter.
  assign lookup_taken = bht_q[lookup_idx][1];

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    src_a_d            = src_a_q;
    src_b_d            = src_b_q;
    op_d               = op_q;
    imm_d              = imm_q;
    pred_d             = pred_q;
    redirect_pc_d      = redirect_pc_q;
    flush_d            = 1'b0;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    bht_d              = bht_q;
    is_branch          = 1'b0;
    mispredict         = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          pc_d    = req_pc;
          src_a_d = req_src_a;
          src_b_d = req_src_b;
          op_d    = req_op;
          imm_d   = req_imm;
          pred_d  = req_pred_taken;
          state_d = EVAL;
        end
      end
      EVAL: begin
        is_branch      = 1'b1;
        mispredict     = bu_taken ^ pred_q;
        branch_count_d = sat_inc16(branch_count_q);
        bht_d[upd_idx] = bht_next(bht_q[upd_idx], bu_taken);
        if (mispredict) begin
          mispredict_count_d = sat_inc16(mispredict_count_q);
          redirect_pc_d      = bu_target;
          // Registered so the flush lands on the first REDIRECT cycle only.
          flush_d            = 1'b1;
          state_d            = REDIRECT;
        end else begin
          state_d = IDLE;
        end
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      pc_q               <= '0;
      src_a_q            <= '0;
      src_b_q            <= '0;
      op_q               <= BR_EQ;
      imm_q              <= '0;
      pred_q             <= 1'b0;
      redirect_pc_q      <= '0;
      flush_q            <= 1'b0;
      branch_count_q     <= CNT_RESET;
      mispredict_count_q <= CNT_RESET;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_RESET;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      src_a_q            <= src_a_d;
      src_b_q            <= src_b_d;
      op_q               <= op_d;
      imm_q              <= imm_d;
      pred_q             <= pred_d;
      redirect_pc_q      <= redirect_pc_d;
      flush_q            <= flush_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      bht_q              <= bht_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign redirect_valid   = (state_q == REDIRECT);
  assign resolve_done     = (state_q == EVAL);
  assign redirect_pc      = redirect_pc_q;
  assign flush            = flush_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl
module tb_branch_ctrl;
  import branches_pkg::*;

  localparam int W = 32;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req_valid, req_pred_taken, redirect_ready;
  logic [W-1:0] req_pc, req_src_a, req_src_b, req_imm, lookup_pc;
  branch_op_e   req_op;

  logic         req_ready, lookup_taken, redirect_valid, flush, resolve_done;
  logic [W-1:0] redirect_pc;
  logic [15:0]  branch_count, mispredict_count;

  logic         s_req_ready, s_lookup_taken, s_redirect_valid, s_flush, s_resolve_done;
  logic [W-1:0] s_redirect_pc;
  logic [15:0]  s_branch_count, s_mispredict_count;

  branch_ctrl #(.WIDTH(W), .BHT_ENTRIES(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_src_a(req_src_a), .req_src_b(req_src_b), .req_op(req_op),
    .req_imm(req_imm), .req_pred_taken(req_pred_taken), .lookup_pc(lookup_pc),
    .lookup_taken(lookup_taken), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush),
    .resolve_done(resolve_done), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  // Second instance with counters preloaded near the limit.
  branch_ctrl #(.WIDTH(W), .BHT_ENTRIES(N), .CNT_RESET(16'hFFFD)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_pc(req_pc), .req_src_a(req_src_a), .req_src_b(req_src_b), .req_op(req_op),
    .req_imm(req_imm), .req_pred_taken(req_pred_taken), .lookup_pc(lookup_pc),
    .lookup_taken(s_lookup_taken), .redirect_valid(s_redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(s_redirect_pc), .flush(s_flush),
    .resolve_done(s_resolve_done), .branch_count(s_branch_count),
    .mispredict_count(s_mispredict_count)
  );

  int n_vec = 0;
  int n_err = 0;

  int bht_m [N];
  int bc_m, mc_m;

  typedef struct {
    int          op;
    logic [31:0] a, b, pc, imm;
    bit          pred;
    int          delay;
    bit          exp_redir;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_taken(input int op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb;
    ua = a;
    ub = b;
    sa = ua - (a[31] ? 64'sd4294967296 : 64'sd0);
    sb = ub - (b[31] ? 64'sd4294967296 : 64'sd0);
    case (op)
      0: return ua == ub;
      1: return ua != ub;
      2: return sa < sb;
      3: return sa >= sb;
      4: return ua < ub;
      5: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    longint p;
    p = pc;
    return int'((p / 4) % N);
  endfunction

  function automatic int sat_exp(input int x);
    return (x + 65533 > 65535) ? 65535 : x + 65533;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < N; i++) bht_m[i] = 1;
    bc_m = 0;
    mc_m = 0;
  endtask

  task automatic do_branch(input int op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] imm, input bit pred,
                           input int delay, input bit noise,
                           output bit redir, output logic [31:0] rpc);
    bit          tk, mis;
    logic [31:0] tgt;
    int          idx;
    tk  = m_taken(op, a, b);
    tgt = tk ? pc + imm : pc + 32'd4;
    mis = (tk != pred);
    idx = m_idx(pc);
    redir = 1'b0;
    rpc   = '0;

    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_pc = pc; req_src_a = a; req_src_b = b;
    req_op = branch_op_e'(3'(op)); req_imm = imm; req_pred_taken = pred;
    lookup_pc = pc;
    #1;
    chk("lookup_before", lookup_taken, (bht_m[idx] >= 2));
    tick();
    // EVAL: requests presented now must be ignored.
    if (noise) begin
      req_valid = 1'b1; req_pc = $urandom; req_src_a = $urandom; req_src_b = $urandom;
      req_imm = $urandom; req_pred_taken = ~pred;
    end else begin
      req_valid = 1'b0;
    end
    #1;
    chk("resolve_done_eval", resolve_done, 1);
    chk("req_ready_eval", req_ready, 0);
    chk("redirect_valid_eval", redirect_valid, 0);
    chk("lookup_same_cycle", lookup_taken, (bht_m[idx] >= 2));
    tick();
    bc_m = bc_m + 1;
    if (mis) mc_m = mc_m + 1;
    if (tk) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
    else    bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;

    if (mis) begin
      redir = 1'b1;
      rpc   = redirect_pc;
      for (int k = 0; k <= delay; k++) begin
        redirect_ready = (k == delay);
        chk("redirect_valid_hold", redirect_valid, 1);
        chk("redirect_pc_hold", redirect_pc, tgt);
        chk("flush_pulse", flush, (k == 0));
        chk("req_ready_redirect", req_ready, 0);
        chk("resolve_done_redirect", resolve_done, 0);
        tick();
      end
      redirect_ready = 1'b0;
    end
    req_valid = 1'b0;
    chk("req_ready_back", req_ready, 1);
    chk("redirect_valid_back", redirect_valid, 0);
    chk("flush_back", flush, 0);
    chk("resolve_done_back", resolve_done, 0);
    chk("branch_count", branch_count, 32'(bc_m > 65535 ? 65535 : bc_m));
    chk("mispredict_count", mispredict_count, 32'(mc_m > 65535 ? 65535 : mc_m));
    chk("sat_branch_count", s_branch_count, 32'(sat_exp(bc_m)));
    chk("sat_mispredict_count", s_mispredict_count, 32'(sat_exp(mc_m)));
    chk("lookup_after", lookup_taken, (bht_m[idx] >= 2));
  endtask

  bit          r;
  logic [31:0] p;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_pc = '0; req_src_a = '0; req_src_b = '0; req_op = BR_EQ;
    req_imm = '0; req_pred_taken = 1'b0; lookup_pc = '0; redirect_ready = 1'b0;
    reset_model();

    tbl[0] = '{op: 1, a: 32'd5, b: 32'd5, pc: 32'h300, imm: 32'h10, pred: 1'b0,
               delay: 0, exp_redir: 1'b0, exp_pc: 32'h0};
    tbl[1] = '{op: 2, a: 32'hFFFFFFFF, b: 32'd1, pc: 32'h10, imm: 32'h8, pred: 1'b0,
               delay: 1, exp_redir: 1'b1, exp_pc: 32'h18};
    tbl[2] = '{op: 5, a: 32'hFFFFFFFF, b: 32'd1, pc: 32'hFFFFFFFC, imm: 32'h8, pred: 1'b0,
               delay: 0, exp_redir: 1'b1, exp_pc: 32'h4};
    tbl[3] = '{op: 2, a: 32'd1, b: 32'hFFFFFFFF, pc: 32'h80, imm: 32'h10, pred: 1'b1,
               delay: 2, exp_redir: 1'b1, exp_pc: 32'h84};
    tbl[4] = '{op: 3, a: 32'h80000000, b: 32'h7FFFFFFF, pc: 32'h0C, imm: 32'h4, pred: 1'b1,
               delay: 0, exp_redir: 1'b1, exp_pc: 32'h10};
    tbl[5] = '{op: 0, a: 32'd7, b: 32'd8, pc: 32'h44, imm: 32'h100, pred: 1'b0,
               delay: 0, exp_redir: 1'b0, exp_pc: 32'h0};
    tbl[6] = '{op: 4, a: 32'd3, b: 32'd3, pc: 32'h48, imm: 32'h20, pred: 1'b1,
               delay: 1, exp_redir: 1'b1, exp_pc: 32'h4C};
    tbl[7] = '{op: 5, a: 32'd3, b: 32'd3, pc: 32'h4C, imm: 32'hFFFFFFF0, pred: 1'b1,
               delay: 0, exp_redir: 1'b0, exp_pc: 32'h0};

    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_resolve_done", resolve_done, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_branch_count", branch_count, 0);
    chk("rst_mispredict_count", mispredict_count, 0);
    chk("rst_sat_branch_count", s_branch_count, 32'hFFFD);
    chk("rst_lookup", lookup_taken, 0);
    rst_n = 1'b1;
    tick();

    // BEQ taken, predicted taken: no redirect, BHT[0] 01->10
    do_branch(0, 32'hA, 32'hA, 32'h100, 32'h20, 1'b1, 0, 1'b0, r, p);
    chk("beq_no_redirect", 32'(r), 0);
    chk("beq_branch_count", branch_count, 1);
    lookup_pc = 32'h100; #1;
    chk("beq_bht0_taken", lookup_taken, 1);

    // BLTU taken, predicted not taken: redirect to 0x38
    do_branch(4, 32'h0, 32'hFFFFFFFF, 32'h40, 32'hFFFFFFF8, 1'b0, 0, 1'b0, r, p);
    chk("bltu_redirect", 32'(r), 1);
    chk("bltu_redirect_pc", p, 32'h38);
    chk("bltu_mispredict_count", mispredict_count, 1);

    // BGE not taken, predicted taken, redirect_ready held low 3 cycles
    do_branch(3, 32'd1, 32'd2, 32'h200, 32'h40, 1'b1, 3, 1'b1, r, p);
    chk("bge_redirect", 32'(r), 1);
    chk("bge_redirect_pc", p, 32'h204);

    for (int i = 0; i < 8; i++) begin
      do_branch(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].pc, tbl[i].imm, tbl[i].pred,
                tbl[i].delay, 1'b1, r, p);
      chk($sformatf("tbl%0d_redirect", i), 32'(r), 32'(tbl[i].exp_redir));
      if (tbl[i].exp_redir) chk($sformatf("tbl%0d_pc", i), p, tbl[i].exp_pc);
    end

    // Three taken branches at one pc saturate the counter
    for (int i = 0; i < 3; i++)
      do_branch(0, 32'd9, 32'd9, 32'h104, 32'h8, 1'b1, 0, 1'b0, r, p);
    lookup_pc = 32'h104; #1;
    chk("sat3_lookup", lookup_taken, 1);
    do_branch(1, 32'd9, 32'd9, 32'h104, 32'h8, 1'b1, 0, 1'b0, r, p);
    chk("sat3_dec_still_taken", lookup_taken, 1);
    do_branch(1, 32'd9, 32'd9, 32'h104, 32'h8, 1'b0, 0, 1'b0, r, p);
    chk("sat3_dec_not_taken", lookup_taken, 0);

    // Reset while in REDIRECT
    req_valid = 1'b1; req_pc = 32'h60; req_src_a = 32'd1; req_src_b = 32'd1;
    req_op = BR_EQ; req_imm = 32'h10; req_pred_taken = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_redirect_valid", redirect_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_redirect_valid", redirect_valid, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_flush", flush, 0);
    chk("arst_redirect_pc", redirect_pc, 0);
    chk("arst_branch_count", branch_count, 0);
    chk("arst_mispredict_count", mispredict_count, 0);
    for (int i = 0; i < N; i++) begin
      lookup_pc = 32'(i * 4);
      #1;
      chk($sformatf("arst_lookup%0d", i), lookup_taken, 0);
    end
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_branch(0, 32'd2, 32'd2, 32'h60, 32'h10, 1'b1, 0, 1'b0, r, p);

    // Randomized against the model
    for (int i = 0; i < 200; i++) begin
      int          op;
      logic [31:0] a, b, pc, imm;
      op  = $urandom_range(0, 5);
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc  = 32'($urandom_range(0, 63)) << 2;
      imm = $urandom_range(0, 1) ? 32'($urandom_range(0, 255)) << 2
                                 : -(32'($urandom_range(1, 255)) << 2);
      do_branch(op, a, b, pc, imm, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), r, p);
    end

    // Preloaded counters stay pinned at the limit
    chk("sat_branch_final", s_branch_count, 32'hFFFF);
    chk("sat_mispredict_final", s_mispredict_count, 32'hFFFF);
    do_branch(0, 32'd1, 32'd2, 32'h20, 32'h8, 1'b1, 0, 1'b0, r, p);
    chk("sat_branch_after", s_branch_count, 32'hFFFF);
    chk("sat_mispredict_after", s_mispredict_count, 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
